// File: rtl/sub4_response_checker_if.sv
// Stimulus/response bus between the response checker (master) and the
// subtractor under test (slave).
interface sub4_response_checker_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] aa;
   logic [WIDTH-1:0] bb;
   logic             bin;
   logic [WIDTH-1:0] dd;
   logic             bout;

   modport master (output aa, output bb, output bin, input dd, input bout);
   modport slave  (input aa, input bb, input bin, output dd, output bout);
endinterface

// File: rtl/sub4_response_checker.sv
// Exhaustive on-chip checker for a WIDTH-bit borrow-ripple subtractor: sweeps
// every {bin, aa, bb}, counts mismatches and latches the first failing vector.
module sub4_response_checker #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   sub4_response_checker_if.master sub_if,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_pass,
   output logic [2*WIDTH+1:0]     o_err_count,
   output logic                   o_fail_valid,
   output logic [2*WIDTH:0]       o_fail_vec
);
   localparam int VW = 2*WIDTH+1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [VW-1:0] LAST_V   = '1;
   localparam logic [CW-1:0] SETTLE_L = CW'(SETTLE-1);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

   state_t          r_state;
   logic [VW-1:0]   r_v;
   logic [CW-1:0]   r_settle;
   logic [VW:0]     r_err;
   logic            r_fail_valid;
   logic [VW-1:0]   r_fail_vec;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;

   logic [WIDTH:0]  w_exp;
   logic            w_mismatch;
   logic [VW:0]     w_err_next;

   // Reference model: borrow is the MSB of the (WIDTH+1)-bit difference.
   assign w_exp      = {1'b0, r_v[2*WIDTH-1:WIDTH]} - {1'b0, r_v[WIDTH-1:0]}
                     - {{WIDTH{1'b0}}, r_v[2*WIDTH]};
   assign w_mismatch = ({sub_if.bout, sub_if.dd} != w_exp);
   assign w_err_next = r_err + {{VW{1'b0}}, w_mismatch};

   // Stimulus comes straight from the vector register, so it only moves with r_v.
   assign sub_if.bb  = r_v[WIDTH-1:0];
   assign sub_if.aa  = r_v[2*WIDTH-1:WIDTH];
   assign sub_if.bin = r_v[2*WIDTH];

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_err_count  = r_err;
   assign o_fail_valid = r_fail_valid;
   assign o_fail_vec   = r_fail_vec;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_v          <= '0;
         r_settle     <= '0;
         r_err        <= '0;
         r_fail_valid <= 1'b0;
         r_fail_vec   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_state      <= S_DRIVE;
                  r_v          <= '0;
                  r_settle     <= '0;
                  r_err        <= '0;
                  r_fail_valid <= 1'b0;
                  r_fail_vec   <= '0;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_pass       <= 1'b0;
               end
            end
            S_DRIVE: begin
               if (r_settle == SETTLE_L) begin
                  r_settle <= '0;
                  r_state  <= S_CHECK;
               end else begin
                  r_settle <= r_settle + CW'(1);
               end
            end
            S_CHECK: begin
               r_err <= w_err_next;
               if (w_mismatch && !r_fail_valid) begin
                  r_fail_valid <= 1'b1;
                  r_fail_vec   <= r_v;
               end
               if (r_v == LAST_V) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_next == '0);
               end else begin
                  r_v     <= r_v + VW'(1);
                  r_state <= S_DRIVE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sub4_response_checker.sv
// Directed bench: a behavioural subtractor with selectable faults feeds two
// checker instances (SETTLE = 1 and SETTLE = 3).
module tb_sub4_response_checker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   int   sel = 0;
   int   fault = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   sub4_response_checker_if #(.WIDTH(4)) bus1 ();
   sub4_response_checker_if #(.WIDTH(4)) bus3 ();

   logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
   logic [9:0] err1, err3;
   logic [8:0] fvec1, fvec3;

   // fault: 0 ideal, 1 bout stuck at 0, 2 dd inverted
   function automatic logic [4:0] sub_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic bi, input int f);
      logic [3:0] d;
      logic       bw;
      bw = bi;
      for (int i = 0; i < 4; i++) begin
         d[i] = a[i] ^ b[i] ^ bw;
         bw   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
      end
      if (f == 1) bw = 1'b0;
      if (f == 2) d = ~d;
      return {bw, d};
   endfunction

   assign {bus1.bout, bus1.dd} = sub_model(bus1.aa, bus1.bb, bus1.bin, fault);
   assign {bus3.bout, bus3.dd} = sub_model(bus3.aa, bus3.bb, bus3.bin, fault);

   sub4_response_checker #(.WIDTH(4), .SETTLE(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start && sel == 0), .sub_if(bus1.master),
      .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_count(err1),
      .o_fail_valid(fv1), .o_fail_vec(fvec1));

   sub4_response_checker #(.WIDTH(4), .SETTLE(3)) dut3 (
      .i_clk(clk), .i_rst(rst), .i_start(start && sel == 1), .sub_if(bus3.master),
      .o_busy(busy3), .o_done(done3), .o_pass(pass3), .o_err_count(err3),
      .o_fail_valid(fv3), .o_fail_vec(fvec3));

   logic       busy, done, pass, fv, bin;
   logic [9:0] errc;
   logic [8:0] fvec;
   logic [3:0] aa, bb;
   assign busy = sel ? busy3 : busy1;
   assign done = sel ? done3 : done1;
   assign pass = sel ? pass3 : pass1;
   assign fv   = sel ? fv3 : fv1;
   assign errc = sel ? err3 : err1;
   assign fvec = sel ? fvec3 : fvec1;
   assign aa   = sel ? bus3.aa : bus1.aa;
   assign bb   = sel ? bus3.bb : bus1.bb;
   assign bin  = sel ? bus3.bin : bus1.bin;

   typedef struct {
      int         fault;
      int         cyc;
      int         err;
      logic       fv;
      logic [8:0] fvec;
      logic       pass;
   } vec_t;
   vec_t tbl[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " pass"}, pass, 0);
      chk({tag, " err_count"}, errc, 0);
      chk({tag, " fail_valid"}, fv, 0);
      chk({tag, " fail_vec"}, fvec, 0);
      chk({tag, " vector"}, {bin, aa, bb}, 0);
   endtask

   // Starts a run at edge E0, returns edges from E0 until done. start is
   // dropped after 'hold' edges (0 = one-cycle pulse).
   task automatic do_run(input int settle, input int hold, output int cyc, output bit ovl);
      ovl = 1'b0;
      cyc = 0;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1;
      if (hold == 0) start = 1'b0;
      chk("E0 busy", busy, 1);
      chk("E0 done", done, 0);
      chk("E0 err_count cleared", errc, 0);
      chk("E0 fail_valid cleared", fv, 0);
      chk("E0 vector 0", {bin, aa, bb}, 0);
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == hold) start = 1'b0;
         if (busy && done) ovl = 1'b1;
         if (cyc == settle)     chk("vector 0 held", bb, 0);
         if (cyc == settle + 1) chk("vector 1 after check", bb, 1);
         if (done) break;
      end
      start = 1'b0;
      chk("done reached", done, 1);
   endtask

   initial begin
      int cyc;
      bit ovl;
      tbl[0] = '{0, 1024, 0,   1'b0, 9'h000, 1'b1};
      tbl[1] = '{1, 1024, 256, 1'b1, 9'h001, 1'b0};
      tbl[2] = '{2, 1024, 512, 1'b1, 9'h000, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         fault = tbl[i].fault;
         do_run(1, 0, cyc, ovl);
         chk($sformatf("t%0d cycles", i), cyc, tbl[i].cyc);
         chk($sformatf("t%0d err_count", i), errc, tbl[i].err);
         chk($sformatf("t%0d fail_valid", i), fv, tbl[i].fv);
         chk($sformatf("t%0d fail_vec", i), fvec, tbl[i].fvec);
         chk($sformatf("t%0d pass", i), pass, tbl[i].pass);
         chk($sformatf("t%0d busy low", i), busy, 0);
         chk($sformatf("t%0d busy/done overlap", i), ovl, 0);
         repeat (5) @(posedge clk);
         #1 chk($sformatf("t%0d done held", i), done, 1);
      end

      // Reset at cycle 300 of a failing run
      fault = 1;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      repeat (298) @(negedge clk);
      chk("pre-reset errors seen", errc != 0, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_vals("mid-run reset");
      @(negedge clk) rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("idle after reset busy", busy, 0);
      chk("idle after reset vector", {bin, aa, bb}, 0);
      fault = 0;
      do_run(1, 0, cyc, ovl);
      chk("post-reset run cycles", cyc, 1024);
      chk("post-reset run pass", pass, 1);

      // start held high mid-run, then restart from DONE with an ideal DUT
      fault = 2;
      do_run(1, 1000, cyc, ovl);
      chk("held-start cycles", cyc, 1024);
      chk("held-start err_count", errc, 512);
      fault = 0;
      do_run(1, 0, cyc, ovl);
      chk("restart cycles", cyc, 1024);
      chk("restart pass", pass, 1);
      chk("restart err_count", errc, 0);

      // SETTLE = 3 instance
      sel = 1;
      fault = 0;
      do_run(3, 0, cyc, ovl);
      chk("settle3 cycles", cyc, 2048);
      chk("settle3 pass", pass, 1);
      chk("settle3 busy/done overlap", ovl, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sub4_response_checker.md
# sub4_response_checker

Hardware self-checking response analyser for the 4-bit borrow-ripple subtractor (`fullSub4`). It drives every `{bin, a, b}` combination into the subtractor, waits for it to settle, and compares `diff`/`bout` against an internal model. It counts mismatches and records the first failing vector. It is the on-chip counterpart to the simulation stimulus bench and is used for board-level checking of the lab subtractor.

## Interface
- `WIDTH`, 4: operand width of the subtractor under test.
- `SETTLE`, 1: cycles each vector is held before comparison; legal range ≥ 1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  level sampled each edge; a start request is recognised only in IDLE or DONE.
- `aa`  out  WIDTH  minuend driven to the DUT.
- `bb`  out  WIDTH  subtrahend driven to the DUT.
- `bin`  out  1  borrow-in driven to the DUT.
- `dd`  in  WIDTH  DUT difference.
- `bout`  in  1  DUT borrow-out.
- `busy`  out  1  high in DRIVE and CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  `done` AND (`err_count` == 0).
- `err_count`  out  2*WIDTH+2  number of mismatching vectors in the last run.
- `fail_valid`  out  1  at least one mismatch has been recorded.
- `fail_vec`  out  2*WIDTH+1  `{bin, aa, bb}` of the first mismatching vector.

## Operation
- Vector index `v` is a (2*WIDTH+1)-bit counter. Decode: `bb` = v[WIDTH-1:0], `aa` = v[2*WIDTH-1:WIDTH], `bin` = v[2*WIDTH].
  - `bb` increments fastest, then `aa`, then `bin`.
  - N = 2^(2*WIDTH+1) vectors; N = 512 for WIDTH = 4.
- Expected result: `{exp_bout, exp_diff}` = {1'b0,aa} − {1'b0,bb} − bin, computed in WIDTH+1 bits.
  - The MSB is the borrow: 1 exactly when aa < bb + bin.
- A mismatch is (`dd` ≠ exp_diff) OR (`bout` ≠ exp_bout). It counts once per vector.
- FSM states and transitions:
  - IDLE: on `start`, go to DRIVE with v = 0.
    - Also clears `err_count`, `fail_valid`, `fail_vec` and the settle counter.
  - DRIVE: hold the current vector. After SETTLE cycles in DRIVE, go to CHECK.
  - CHECK (one cycle):
    - Compare the DUT outputs against the model.
    - On mismatch, increment `err_count`.
    - On the first mismatch only, set `fail_valid` and capture `fail_vec`.
    - If v == N−1, go to DONE. Otherwise increment v and go to DRIVE.
  - DONE: results held stable.
    - `start` restarts exactly as from IDLE, clearing all results.
    - Without `start`, stay in DONE indefinitely.
- `start` in DRIVE/CHECK is ignored; there is no abort except `rst`.
- `err_count` cannot overflow: its maximum is N = 512, which fits in 10 bits.
- `aa`, `bb` and `bin` are registered outputs and change only on state/index updates.

## Timing
- Reset values: state IDLE; `aa` = 0, `bb` = 0, `bin` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, `fail_valid` = 0, `fail_vec` = 0.
- `rst` mid-run (any state) returns to IDLE at that edge with all reset values. `rst` has priority over `start` in the same cycle.
- Let E0 be the edge that samples `start`.
  - After E0: `busy` = 1 and vector 0 is on `aa`/`bb`/`bin`.
  - Vector k is compared at edge E0 + (k+1)·(SETTLE+1).
- `done` rises, and `busy` falls, after edge E0 + N·(SETTLE+1). That is 1024 cycles for the defaults and 2048 for SETTLE = 3.
- `busy` and `done` are never high together. `pass` is valid only while `done` = 1.
- `err_count`, `fail_valid` and `fail_vec` update only at CHECK edges, so they are monotonic during a run.

## Test plan
- Ideal behavioural subtractor connected, `start` pulsed one cycle:
  - `done` = 1 exactly 1024 edges after E0.
  - `err_count` = 0, `pass` = 1, `fail_valid` = 0.
- `bout` stuck at 0:
  - `err_count` = 256 (120 vectors with bin = 0, 136 with bin = 1).
  - `fail_vec` = 9'h001 (aa = 0, bb = 1), `pass` = 0.
- `dd` forced to the bitwise inverse of the correct value:
  - `err_count` = 512.
  - `fail_vec` = 9'h000, `fail_valid` = 1.
- `rst` asserted for one cycle at cycle 300 of a run:
  - Next cycle: all outputs at their reset values and state IDLE.
  - No progress until a new `start`.
  - A new run then completes normally.
- `start` held high throughout a run (no effect mid-run), then pulsed in DONE after a failing run:
  - `err_count` and `fail_valid` clear at that edge.
  - The second run, with an ideal DUT, ends with `pass` = 1.
- SETTLE = 3:
  - Each vector is held 3 cycles, plus 1 CHECK cycle.
  - `done` rises 2048 edges after E0 with an ideal DUT.
